pipeline_hazard_ctrl: RTL and testbench

- Stall/flush sequencer for the 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers plus PC).
- Generates per-register hold-enable and flush-to-NOP strobes.
- Resolves load-use hazards, taken-branch redirects, data-memory wait states and ECALL/EBREAK halt drain.
- Sits beside the datapath in the core top level. Pipeline registers consume its outputs: flush loads the reset/NOP value; en=0 holds the current value.

---
 rtl/pipeline_hazard_ctrl.sv | 275 +++++++++++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Stall/flush sequencer for a 5-stage pipeline (PC, IF/ID, ID/EX, EX/MEM,
// MEM/WB). It produces a hold-enable (*_en, 0 = hold) and a NOP-load strobe
// (*_flush, takes priority over en in the consuming register) for each
// pipeline register. It resolves:
//   - data-memory wait states (whole front of the pipe freezes, MEM/WB gets
//     a bubble), with a timeout that halts the core and sets a sticky fault
//   - taken branches/jumps in EX (squash IF/ID and ID/EX)
//   - load-use hazards (one bubble into ID/EX, PC and IF/ID hold)
//   - ECALL/EBREAK in ID (stop fetching, let older instructions retire for
//     DRAIN_CYCLES cycles, then halt until reset)
//
// Parameters:
//   DRAIN_CYCLES : cycles with fetch stopped before HALTED (counted from the
//                  cycle the halt instruction is seen in ID)
//   MEM_TIMEOUT  : frozen memory cycles tolerated before a fault
//   CNT_W        : performance counter width (PIPE_PERF_CNT_EN builds only)
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   id_rs1_addr/id_rs2_addr         source registers of the ID instruction
//   id_uses_rs1/id_uses_rs2         ID instruction really reads rs1/rs2
//   id_halt                         ID instruction is ECALL/EBREAK
//   ex_MemRead, ex_rd_addr          EX instruction is a load / its rd
//   ex_branch_taken                 EX redirects the PC
//   mem_MemRead/mem_MemWrite        MEM stage accesses data memory
//   dmem_ready                      data memory finishes this cycle
//   pc_en, *_en, *_flush            pipeline register controls
//   halted                          core stopped
//   mem_fault                       sticky memory-timeout flag
//
// Optional feature (macro PIPE_PERF_CNT_EN): adds saturating counters
//   stall_cnt, flush_cnt, memwait_cnt of width CNT_W.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int MEM_TIMEOUT  = 16
`ifdef PIPE_PERF_CNT_EN
  ,
  parameter int CNT_W        = 32
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       id_halt,
  input  logic       ex_MemRead,
  input  logic [4:0] ex_rd_addr,
  input  logic       ex_branch_taken,
  input  logic       mem_MemRead,
  input  logic       mem_MemWrite,
  input  logic       dmem_ready,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       if_id_flush,
  output logic       id_ex_en,
  output logic       id_ex_flush,
  output logic       ex_mem_en,
  output logic       mem_wb_en,
  output logic       mem_wb_flush,
  output logic       halted,
  output logic       mem_fault
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] memwait_cnt
`endif
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_DRAIN    = 2'd2,
    S_HALTED   = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [TW-1:0] tcnt;
  logic [TW-1:0] tcnt_next;
  logic [TW-1:0] tcnt_base;
  logic [TW-1:0] tcnt_inc;
  logic [DW-1:0] dcnt;
  logic [DW-1:0] dcnt_next;
  logic          fault_set;
  logic          mem_stall;
  logic          load_use;

  assign mem_stall = (mem_MemRead | mem_MemWrite) & ~dmem_ready;

  // x0 is never a real dependency, so a load to x0 cannot cause a stall.
  assign load_use = ex_MemRead & (ex_rd_addr != 5'd0) &
                    ((id_uses_rs1 & (id_rs1_addr == ex_rd_addr)) |
                     (id_uses_rs2 & (id_rs2_addr == ex_rd_addr)));

  // Output decode and next-state/counter computation.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    mem_wb_flush = 1'b0;
    halted       = 1'b0;
    state_next   = state;
    tcnt_next    = tcnt;
    dcnt_next    = dcnt;
    fault_set    = 1'b0;
    // A freeze entered from RUN starts a fresh count; MEM_WAIT and DRAIN
    // continue the running count.
    if (state == S_RUN) begin
      tcnt_base = {TW{1'b0}};
    end else begin
      tcnt_base = tcnt;
    end
    tcnt_inc = tcnt_base + TW'(1);

    if (reset) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_en     = 1'b0;
      id_ex_flush  = 1'b1;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      mem_wb_flush = 1'b1;
      state_next   = S_RUN;
      tcnt_next    = {TW{1'b0}};
      dcnt_next    = {DW{1'b0}};
    end else begin
      case (state)
        S_RUN, S_MEM_WAIT, S_DRAIN: begin
          if (mem_stall) begin
            // Freeze everything upstream of MEM; MEM/WB takes a bubble.
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
            if (tcnt_inc >= TW'(MEM_TIMEOUT)) begin
              fault_set  = 1'b1;
              state_next = S_HALTED;
              tcnt_next  = TW'(MEM_TIMEOUT);
            end else begin
              // DRAIN stays in DRAIN with its drain count paused.
              state_next = (state == S_DRAIN) ? S_DRAIN : S_MEM_WAIT;
              tcnt_next  = tcnt_inc;
            end
          end else if (state == S_DRAIN) begin
            // Halt is older than anything in EX, so branches are ignored.
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
            tcnt_next   = {TW{1'b0}};
            if (dcnt >= DW'(DRAIN_CYCLES - 1)) begin
              state_next = S_HALTED;
              dcnt_next  = DW'(DRAIN_CYCLES);
            end else begin
              dcnt_next  = dcnt + DW'(1);
            end
          end else begin
            // RUN, or the cycle MEM_WAIT sees dmem_ready.
            state_next = S_RUN;
            tcnt_next  = {TW{1'b0}};
            if (ex_branch_taken) begin
              if_id_flush = 1'b1;
              id_ex_flush = 1'b1;
            end else if (load_use) begin
              pc_en       = 1'b0;
              if_id_en    = 1'b0;
              id_ex_flush = 1'b1;
            end else if (id_halt) begin
              // The cycle the halt sits in ID is the first drain cycle.
              pc_en       = 1'b0;
              if_id_flush = 1'b1;
              dcnt_next   = DW'(1);
              if (DRAIN_CYCLES <= 1) begin
                state_next = S_HALTED;
              end else begin
                state_next = S_DRAIN;
              end
            end else begin
              state_next = S_RUN;
            end
          end
        end
        S_HALTED: begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_mem_en = 1'b0;
          mem_wb_en = 1'b0;
          halted    = 1'b1;
        end
        default: begin
          // Unreachable encoding: hold the pipe in NOPs and recover to RUN.
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          if_id_flush  = 1'b1;
          id_ex_en     = 1'b0;
          id_ex_flush  = 1'b1;
          ex_mem_en    = 1'b0;
          mem_wb_en    = 1'b0;
          mem_wb_flush = 1'b1;
          state_next   = S_RUN;
          tcnt_next    = {TW{1'b0}};
          dcnt_next    = {DW{1'b0}};
        end
      endcase
    end
  end

  // State, counters and the sticky fault flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_RUN;
      tcnt      <= {TW{1'b0}};
      dcnt      <= {DW{1'b0}};
      mem_fault <= 1'b0;
    end else begin
      state <= state_next;
      tcnt  <= tcnt_next;
      dcnt  <= dcnt_next;
      if (fault_set) begin
        mem_fault <= 1'b1;
      end else begin
        mem_fault <= mem_fault;
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Events are recognised from the decoded strobes: each pattern below is
  // unique to its scenario (reset and HALTED never match any of them).
  logic ev_stall;
  logic ev_flush;
  logic ev_frozen;

  assign ev_stall  = ~if_id_en & id_ex_flush & id_ex_en;
  assign ev_flush  = if_id_flush & id_ex_flush & pc_en;
  assign ev_frozen = mem_wb_flush & ~if_id_flush;

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt   <= {CNT_W{1'b0}};
      flush_cnt   <= {CNT_W{1'b0}};
      memwait_cnt <= {CNT_W{1'b0}};
    end else begin
      if (ev_stall && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (ev_flush && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
      if (ev_frozen && (memwait_cnt != {CNT_W{1'b1}})) begin
        memwait_cnt <= memwait_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl. Inputs change on the falling
// edge; the combinational outputs are sampled 1 ns later, well before the
// next rising edge. Output vector order:
//   {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
//    ex_mem_en, mem_wb_en, mem_wb_flush, halted, mem_fault}
`timescale 1ns/1ps

module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] id_rs1_addr = 5'd0;
  logic [4:0] id_rs2_addr = 5'd0;
  logic       id_uses_rs1 = 1'b0;
  logic       id_uses_rs2 = 1'b0;
  logic       id_halt = 1'b0;
  logic       ex_MemRead = 1'b0;
  logic [4:0] ex_rd_addr = 5'd0;
  logic       ex_branch_taken = 1'b0;
  logic       mem_MemRead = 1'b0;
  logic       mem_MemWrite = 1'b0;
  logic       dmem_ready = 1'b1;
  logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic       ex_mem_en, mem_wb_en, mem_wb_flush, halted, mem_fault;
`ifdef PIPE_PERF_CNT_EN
  logic [3:0] stall_cnt, flush_cnt, memwait_cnt;
`endif

  int total = 0;
  int bad   = 0;

  localparam logic [9:0] RST  = 10'b0010100100;
  localparam logic [9:0] RUNV = 10'b1101011000;
  localparam logic [9:0] LU   = 10'b0001111000;
  localparam logic [9:0] BR   = 10'b1111111000;
  localparam logic [9:0] FRZ  = 10'b0000001100;
  localparam logic [9:0] DR   = 10'b0111011000;
  localparam logic [9:0] HLT  = 10'b0000000010;
  localparam logic [9:0] HF   = 10'b0000000011;

  logic [9:0] obs;
  assign obs = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                ex_mem_en, mem_wb_en, mem_wb_flush, halted, mem_fault};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .DRAIN_CYCLES(3),
    .MEM_TIMEOUT(16)
`ifdef PIPE_PERF_CNT_EN
    ,
    .CNT_W(4)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_halt(id_halt), .ex_MemRead(ex_MemRead), .ex_rd_addr(ex_rd_addr),
    .ex_branch_taken(ex_branch_taken), .mem_MemRead(mem_MemRead),
    .mem_MemWrite(mem_MemWrite), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .mem_wb_flush(mem_wb_flush),
    .halted(halted), .mem_fault(mem_fault)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .memwait_cnt(memwait_cnt)
`endif
  );

  // Advance to the falling edge, apply one input vector, let it settle.
  task automatic step(input logic [4:0] exrd, input logic exmr,
                      input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2,
                      input logic halt, input logic br,
                      input logic mr, input logic mw, input logic rdy);
    @(negedge clk);
    ex_rd_addr = exrd; ex_MemRead = exmr;
    id_rs1_addr = rs1; id_uses_rs1 = u1;
    id_rs2_addr = rs2; id_uses_rs2 = u2;
    id_halt = halt; ex_branch_taken = br;
    mem_MemRead = mr; mem_MemWrite = mw; dmem_ready = rdy;
    #1;
  endtask

  task automatic idle();
    step(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    ex_MemRead = 1'b0; id_halt = 1'b0; ex_branch_taken = 1'b0;
    mem_MemRead = 1'b0; mem_MemWrite = 1'b0; dmem_ready = 1'b1;
    @(negedge clk); #1;
    total++; if (obs !== RST) begin bad++; $display("FAIL reset_outputs got=%b want=%b", obs, RST); end
    reset = 1'b0;
    idle();
    total++; if (obs !== RUNV) begin bad++; $display("FAIL reset_release got=%b want=%b", obs, RUNV); end
  endtask

  task automatic test_load_use();
    step(5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    total++; if (obs !== LU) begin bad++; $display("FAIL lu_rs1 got=%b want=%b", obs, LU); end
    idle();
    total++; if (obs !== RUNV) begin bad++; $display("FAIL lu_one_bubble got=%b want=%b", obs, RUNV); end
    step(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    total++; if (obs !== RUNV) begin bad++; $display("FAIL lu_x0 got=%b want=%b", obs, RUNV); end
    step(5'd7, 1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    total++; if (obs !== LU) begin bad++; $display("FAIL lu_rs2 got=%b want=%b", obs, LU); end
    step(5'd7, 1'b1, 5'd7, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    total++; if (obs !== RUNV) begin bad++; $display("FAIL lu_unused_src got=%b want=%b", obs, RUNV); end
    step(5'd5, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    total++; if (obs !== RUNV) begin bad++; $display("FAIL lu_not_load got=%b want=%b", obs, RUNV); end
  endtask

  task automatic test_branch();
    step(5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    total++; if (obs !== BR) begin bad++; $display("FAIL br_over_lu got=%b want=%b", obs, BR); end
    step(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    total++; if (obs !== BR) begin bad++; $display("FAIL br_over_halt got=%b want=%b", obs, BR); end
    idle();
    total++; if (obs !== RUNV) begin bad++; $display("FAIL br_halt_squashed got=%b want=%b", obs, RUNV); end
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 4; i++) begin
      step(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, (i == 0), 1'b1, 1'b0, 1'b0);
      total++; if (obs !== FRZ) begin bad++; $display("FAIL memwait_freeze[%0d] got=%b want=%b", i, obs, FRZ); end
    end
    step(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    total++; if (obs !== RUNV) begin bad++; $display("FAIL memwait_ready got=%b want=%b", obs, RUNV); end
    idle();
    total++; if (obs !== RUNV) begin bad++; $display("FAIL memwait_back_run got=%b want=%b", obs, RUNV); end
    for (int i = 0; i < 2; i++) begin
      step(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      total++; if (obs !== FRZ) begin bad++; $display("FAIL memwait_wr_freeze[%0d] got=%b want=%b", i, obs, FRZ); end
    end
    step(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    total++; if (obs !== BR) begin bad++; $display("FAIL memwait_ready_branch got=%b want=%b", obs, BR); end
    idle();
    total++; if (obs !== RUNV) begin bad++; $display("FAIL memwait_after_branch got=%b want=%b", obs, RUNV); end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 16; i++) begin
      step(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      total++; if (obs !== FRZ) begin bad++; $display("FAIL timeout_freeze[%0d] got=%b want=%b", i, obs, FRZ); end
    end
    step(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    total++; if (obs !== HF) begin bad++; $display("FAIL timeout_halted got=%b want=%b", obs, HF); end
    step(5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    total++; if (obs !== HF) begin bad++; $display("FAIL timeout_sticky got=%b want=%b", obs, HF); end
    test_reset();
  endtask

  task automatic test_halt_drain();
    step(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    total++; if (obs !== DR) begin bad++; $display("FAIL drain_c1 got=%b want=%b", obs, DR); end
    step(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    total++; if (obs !== DR) begin bad++; $display("FAIL drain_c2_branch got=%b want=%b", obs, DR); end
    idle();
    total++; if (obs !== DR) begin bad++; $display("FAIL drain_c3 got=%b want=%b", obs, DR); end
    idle();
    total++; if (obs !== HLT) begin bad++; $display("FAIL drain_halted got=%b want=%b", obs, HLT); end
    step(5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    total++; if (obs !== HLT) begin bad++; $display("FAIL halted_hold got=%b want=%b", obs, HLT); end
    test_reset();
  endtask

  task automatic test_drain_freeze();
    step(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    total++; if (obs !== DR) begin bad++; $display("FAIL dfrz_c1 got=%b want=%b", obs, DR); end
    step(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    total++; if (obs !== FRZ) begin bad++; $display("FAIL dfrz_freeze got=%b want=%b", obs, FRZ); end
    idle();
    total++; if (obs !== DR) begin bad++; $display("FAIL dfrz_c2 got=%b want=%b", obs, DR); end
    idle();
    total++; if (obs !== DR) begin bad++; $display("FAIL dfrz_c3 got=%b want=%b", obs, DR); end
    idle();
    total++; if (obs !== HLT) begin bad++; $display("FAIL dfrz_halted got=%b want=%b", obs, HLT); end
    test_reset();
  endtask

  task automatic test_back_to_back();
    step(5'd9, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    total++; if (obs !== LU) begin bad++; $display("FAIL b2b_lu1 got=%b want=%b", obs, LU); end
    step(5'd4, 1'b1, 5'd1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    total++; if (obs !== LU) begin bad++; $display("FAIL b2b_lu2 got=%b want=%b", obs, LU); end
    step(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    total++; if (obs !== BR) begin bad++; $display("FAIL b2b_branch got=%b want=%b", obs, BR); end
    idle();
    total++; if (obs !== RUNV) begin bad++; $display("FAIL b2b_run got=%b want=%b", obs, RUNV); end
  endtask

`ifdef PIPE_PERF_CNT_EN
  task automatic test_perf();
    test_reset();
    total++; if (stall_cnt !== 4'd0) begin bad++; $display("FAIL perf_reset got=%0d want=0", stall_cnt); end
    for (int i = 0; i < 20; i++) begin
      step(5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      step(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    for (int i = 0; i < 2; i++) begin
      step(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    step(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle();
    total++; if (stall_cnt !== 4'd15) begin bad++; $display("FAIL perf_stall_sat got=%0d want=15", stall_cnt); end
    total++; if (flush_cnt !== 4'd3) begin bad++; $display("FAIL perf_flush got=%0d want=3", flush_cnt); end
    total++; if (memwait_cnt !== 4'd2) begin bad++; $display("FAIL perf_memwait got=%0d want=2", memwait_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_back_to_back();
    test_timeout();
    test_halt_drain();
    test_drain_freeze();
`ifdef PIPE_PERF_CNT_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
